// File: rtl/matvec_pkg.sv
// matvec_pkg: geometry helpers and requantization shared by matvec_mul and its users.
package matvec_pkg;

  // Adder-tree depth of a C-column dot product.
  function automatic int mv_depth(input int c);
    return $clog2(c);
  endfunction

  // Full-precision product/accumulator width.
  function automatic int mv_w_y(input int w_x, input int w_k, input int c);
    return w_x + w_k + mv_depth(c);
  endfunction

  // matvec_mul latency in enabled cycles.
  function automatic int mv_lat(input int c);
    return mv_depth(c) + 1;
  endfunction

  // Working width for rq_sat; wide enough that the rounding add never overflows
  // for any accumulator width used in practice, so the result equals a W_Y+1-bit computation.
  localparam int RQ_W = 64;

  // Round-half-up arithmetic right shift, then saturate to a signed w_o-bit range.
  function automatic logic signed [RQ_W-1:0] rq_sat(input logic signed [RQ_W-1:0] v,
                                                    input int shift, input int w_o);
    logic signed [RQ_W-1:0] t;
    logic signed [RQ_W-1:0] hi;
    logic signed [RQ_W-1:0] lo;
    t = v;
    if (shift > 0) t = t + (RQ_W'(1) <<< (shift - 1));
    t  = t >>> shift;
    hi = (RQ_W'(1) <<< (w_o - 1)) - RQ_W'(1);
    lo = -(RQ_W'(1) <<< (w_o - 1));
    if (t > hi) t = hi;
    else if (t < lo) t = lo;
    return t;
  endfunction

endpackage

// File: rtl/requant_sat.sv
// requant_sat: combinational requantizer from a W_IN-bit accumulator to W_O bits.
module requant_sat #(
  parameter int W_IN  = 19,
  parameter int W_O   = 8,
  parameter int SHIFT = 4
) (
  input  logic signed [W_IN-1:0] din,
  output logic signed [W_O-1:0]  dout
);
  import matvec_pkg::*;

  // The sign-extending cast feeds the shared helper; only the low W_O bits
  // are meaningful after saturation.
  assign dout = W_O'(rq_sat(RQ_W'(din), SHIFT, W_O));

endmodule

// File: rtl/matvec_result_reader.sv
// matvec_result_reader: flow control around a free-running matvec_mul and a
// row-by-row serializer of each finished y vector, requantized to W_O bits.
module matvec_result_reader
  import matvec_pkg::*;
#(
  parameter int R     = 8,
  parameter int C     = 8,
  parameter int W_X   = 8,
  parameter int W_K   = 8,
  parameter int W_O   = 8,
  parameter int SHIFT = 4,
  localparam int DEPTH = mv_depth(C),
  localparam int W_Y   = W_X + W_K + DEPTH,
  localparam int LAT   = DEPTH + 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  mv_cen,
  input  logic [R*W_Y-1:0]      mv_y,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic signed [W_O-1:0] m_data,
  output logic                  m_last
);

  localparam int IDX_W = (R > 1) ? $clog2(R) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(R - 1);

  logic [LAT-1:0]   vpipe_q, vpipe_d;
  logic [R*W_Y-1:0] h_q, h_d;
  logic             h_full_q, h_full_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic             beat;
  logic             beat_done;
  logic             load;

  logic signed [W_Y-1:0] h_row [R];

  // View the hold register as R signed rows for the serializer mux.
  for (genvar gi = 0; gi < R; gi++) begin : g_row
    assign h_row[gi] = h_q[gi*W_Y +: W_Y];
  end

  assign beat      = h_full_q && m_ready;
  assign beat_done = beat && (idx_q == IDX_LAST);
  // Stall only when a valid result is waiting at the pipe exit and H cannot
  // take it this edge; a completing last beat frees H in the same cycle.
  assign mv_cen    = !(vpipe_q[LAT-1] && h_full_q && !beat_done);
  assign s_ready   = mv_cen;
  assign load      = mv_cen && vpipe_q[LAT-1];

  assign m_valid   = h_full_q;
  assign m_last    = (idx_q == IDX_LAST);

  // Next-state for the valid pipe, hold register, occupancy flag and row index.
  always_comb begin
    vpipe_d  = vpipe_q;
    h_d      = h_q;
    h_full_d = h_full_q;
    idx_d    = idx_q;
    if (mv_cen) begin
      vpipe_d[0] = s_valid;
      for (int i = 1; i < LAT; i++) vpipe_d[i] = vpipe_q[i-1];
    end
    if (load) begin
      h_d      = mv_y;
      h_full_d = 1'b1;
    end else if (beat_done) begin
      h_full_d = 1'b0;
    end
    if (beat) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
  end

  // State registers; reset discards all in-flight vectors.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vpipe_q  <= '0;
      h_q      <= '0;
      h_full_q <= 1'b0;
      idx_q    <= '0;
    end else begin
      vpipe_q  <= vpipe_d;
      h_q      <= h_d;
      h_full_q <= h_full_d;
      idx_q    <= idx_d;
    end
  end

  requant_sat #(
    .W_IN (W_Y),
    .W_O  (W_O),
    .SHIFT(SHIFT)
  ) u_rq (
    .din (h_row[idx_q]),
    .dout(m_data)
  );

endmodule

// File: tb/tb_matvec_result_reader.sv
// tb_matvec_result_reader: directed and random checks of the reader against a
// behavioural matvec_mul latency model and a scoreboard of expected beats.
module tb_matvec_result_reader;

  localparam int R     = 8;
  localparam int C     = 8;
  localparam int W_X   = 8;
  localparam int W_K   = 8;
  localparam int W_O   = 8;
  localparam int SHIFT = 4;
  localparam int W_Y   = 19;
  localparam int LAT   = 4;
  localparam longint MAXO = 127;
  localparam longint MINO = -128;

  typedef struct {
    int data;
    int last;
  } exp_t;

  logic               clk = 1'b0;
  logic               rstn;
  logic               s_valid;
  logic               s_ready;
  logic               mv_cen;
  logic [R*W_Y-1:0]   mv_y;
  logic               m_valid;
  logic               m_ready;
  logic signed [W_O-1:0] m_data;
  logic               m_last;

  logic [R*W_Y-1:0]   cur_y;
  logic [R*W_Y-1:0]   ypipe [LAT];

  exp_t sb [$];
  int   checks = 0;
  int   failures = 0;
  int   beat_cnt = 0;
  int   acc_cnt = 0;
  logic prev_stall = 1'b0;
  int   prev_data = 0;
  int   prev_last = 0;
  int   mon_got;
  exp_t mon_e;

  always #5 clk = ~clk;

  matvec_result_reader #(
    .R(R), .C(C), .W_X(W_X), .W_K(W_K), .W_O(W_O), .SHIFT(SHIFT)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .mv_cen (mv_cen),
    .mv_y   (mv_y),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .m_last (m_last)
  );

  // matvec_mul stand-in: reset-less, LAT enabled cycles from presented product to y.
  always @(posedge clk) begin
    if (mv_cen) begin
      ypipe[0] <= cur_y;
      for (int i = 1; i < LAT; i++) ypipe[i] <= ypipe[i-1];
    end
  end
  assign mv_y = ypipe[LAT-1];

  // Reference requantizer: floor((y + 2^(SHIFT-1)) / 2^SHIFT), clamped to W_O bits.
  function automatic int rq_ref(input longint y);
    longint dv, num, t;
    dv  = longint'(1) << SHIFT;
    num = y + ((SHIFT > 0) ? (dv / 2) : 0);
    if (num >= 0) t = num / dv;
    else          t = -((-num + dv - 1) / dv);
    if (t > MAXO) t = MAXO;
    if (t < MINO) t = MINO;
    return int'(t);
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_row(input int r, input longint v);
    cur_y[r*W_Y +: W_Y] = W_Y'(v);
  endtask

  task automatic set_all(input longint v);
    for (int r = 0; r < R; r++) set_row(r, v);
  endtask

  task automatic rand_y();
    for (int r = 0; r < R; r++) begin
      if ($urandom_range(0, 1) == 1) set_row(r, longint'($urandom_range(0, 4095)) - 2048);
      else                           cur_y[r*W_Y +: W_Y] = W_Y'($urandom);
    end
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while ((sb.size() != 0 || m_valid) && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  // Scoreboard: push R expected rows per accepted vector, pop one per beat.
  always @(negedge clk) begin
    if (!rstn) begin
      sb.delete();
      prev_stall <= 1'b0;
    end else begin
      mon_got = $signed(m_data);
      if (prev_stall) begin
        check("stall_valid", m_valid, 1);
        check("stall_data", mon_got, prev_data);
        check("stall_last", m_last, prev_last);
      end
      if (m_valid && m_ready) begin
        check("beat_expected", (sb.size() > 0) ? 1 : 0, 1);
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          check("m_data", mon_got, mon_e.data);
          check("m_last", m_last, mon_e.last);
        end
        beat_cnt <= beat_cnt + 1;
      end
      if (s_valid && s_ready) begin
        for (int r = 0; r < R; r++) begin
          exp_t e;
          e.data = rq_ref($signed(cur_y[r*W_Y +: W_Y]));
          e.last = (r == R - 1) ? 1 : 0;
          sb.push_back(e);
        end
        acc_cnt <= acc_cnt + 1;
      end
      prev_stall <= m_valid && !m_ready;
      prev_data  <= mon_got;
      prev_last  <= m_last;
    end
  end

  // Hard stop if anything hangs.
  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int a0, b0, win_acc, gaps, n;
    rstn = 1'b0; s_valid = 1'b0; m_ready = 1'b0; cur_y = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_m_valid", m_valid, 0);
    rstn = 1'b1;
    @(posedge clk); #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", $signed(m_data), 0);
    check("rst_m_last", m_last, 0);
    check("rst_mv_cen", mv_cen, 1);
    check("rst_s_ready", s_ready, 1);

    // 1: k=1, x=16 -> y=128 -> 8; single pulse, latency LAT
    m_ready = 1'b1;
    set_all(C * 16 * 1);
    s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t1_before_lat", m_valid, 0);
    @(posedge clk); #1;
    check("t1_first_valid", m_valid, 1);
    check("t1_first_data", $signed(m_data), 8);
    check("t1_first_last", m_last, 0);
    drain(40);

    // 2: positive and negative saturation
    s_valid = 1'b1;
    set_all(C * 127 * 127);
    @(posedge clk); #1;
    set_all(C * (-128) * 127);
    @(posedge clk); #1;
    s_valid = 1'b0;
    drain(60);

    // 3: rounding at the half points
    cur_y = '0;
    set_row(0, 24); set_row(1, 23); set_row(2, -24); set_row(3, -25);
    s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    drain(40);

    // 4: backpressure fills pipe + hold, then drains in order
    a0 = acc_cnt;
    m_ready = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rand_y();
      @(posedge clk); #1;
    end
    check("t4_accepted", acc_cnt - a0, 5);
    check("t4_s_ready", s_ready, 0);
    check("t4_mv_cen", mv_cen, 0);
    b0 = beat_cnt;
    s_valid = 1'b0;
    m_ready = 1'b1;
    drain(100);
    check("t4_beats", beat_cnt - b0, 40);

    // 5: sustained throughput, one vector per R cycles with no bubbles
    win_acc = 0; gaps = 0;
    s_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      rand_y();
      @(negedge clk);
      if (i >= 16) begin
        if (s_valid && s_ready) win_acc++;
        if (!m_valid) gaps++;
      end
      @(posedge clk); #1;
    end
    check("t5_window_accepts", win_acc, 6);
    check("t5_bubbles", gaps, 0);
    s_valid = 1'b0;
    drain(100);

    // 5b: random valid/ready
    a0 = acc_cnt; b0 = beat_cnt;
    for (int i = 0; i < 300; i++) begin
      s_valid = ($urandom_range(0, 1) == 1);
      m_ready = ($urandom_range(0, 3) != 0);
      rand_y();
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    drain(200);
    check("t5_rand_balance", beat_cnt - b0, (acc_cnt - a0) * R);

    // 6: reset with three vectors in flight and idx=3
    b0 = beat_cnt;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_y();
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    n = 0;
    while ((beat_cnt - b0) != 3 && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    check("t6_reached_idx3", beat_cnt - b0, 3);
    rstn = 1'b0;
    #1;
    check("t6_async_drop", m_valid, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    b0 = beat_cnt;
    repeat (20) @(posedge clk);
    #1;
    check("t6_no_stale_beats", beat_cnt - b0, 0);
    check("t6_idle_valid", m_valid, 0);
    for (int r = 0; r < R; r++) set_row(r, 16 * (r + 1));
    s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (LAT) @(posedge clk);
    #1;
    check("t6_new_valid", m_valid, 1);
    check("t6_new_row0", $signed(m_data), 1);
    check("t6_new_last", m_last, 0);
    drain(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
